// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit: operation encodings and the
// accumulate-mode constant used by the decoder and the tests.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_ANDN = 3'b110,
    OP_ACCX = 3'b111
  } op_t;

  localparam logic [2:0] ACCX_CODE = OP_ACCX;

  // A beat produces a FIFO entry unless it is a non-final accumulate beat.
  function automatic logic produces_result(logic [2:0] code, logic last);
    return (code != ACCX_CODE) || last;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. The head output holds the last popped
// word while empty so downstream never sees X.
module sync_fifo #(
  parameter int DW    = 34,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] last_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      if (do_pop)  last_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: op decode, XOR accumulator and result flags,
// feeding a small output FIFO behind a valid/ready handshake.
module bitwise_logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             out_zero,
  output logic             acc_busy
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  op_t              op;
  logic             accept, push, pop, is_accx;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_busy_q, acc_busy_d;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] head;

  assign op       = op_t'(in_op);
  assign is_accx  = (in_op == ACCX_CODE);
  assign in_ready = rst_n && (count < CW'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && produces_result(in_op, in_last);
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_XNOR: result = ~(in_a ^ in_b);
      OP_NAND: result = ~(in_a & in_b);
      OP_NOR:  result = ~(in_a | in_b);
      OP_ANDN: result = in_a & ~in_b;
      OP_ACCX: result = acc_q ^ in_a ^ in_b;
      default: result = '0;
    endcase
  end

  // Non-ACCX beats leave the accumulator alone so an open sequence resumes.
  always_comb begin
    acc_d      = acc_q;
    acc_busy_d = acc_busy_q;
    if (accept && is_accx) begin
      if (in_last) begin
        acc_d      = '0;
        acc_busy_d = 1'b0;
      end else begin
        acc_d      = result;
        acc_busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_busy_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_busy_q <= acc_busy_d;
    end
  end

  sync_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({^result, (result == '0), result}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign out_data   = head[WIDTH-1:0];
  assign out_zero   = head[WIDTH];
  assign out_parity = head[WIDTH+1];
  assign acc_busy   = acc_busy_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: a negedge monitor models every
// accepted beat and compares each popped result against the queued expectation.
module tb_bitwise_logic_unit;
  import logic_pkg::*;

  localparam int WIDTH = 32;
  localparam int OUT_DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic             out_zero;
  logic             acc_busy;

  int vectors = 0;
  int miscompares = 0;
  int cycles = 0;
  bit randReady = 1'b0;

  logic [WIDTH+1:0] expQ[$];
  logic [WIDTH-1:0] modelAcc;

  bitwise_logic_unit #(.WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_zero   (out_zero),
    .acc_busy   (acc_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH-1:0] refOp(logic [2:0] code, logic [WIDTH-1:0] a,
                                             logic [WIDTH-1:0] b, logic [WIDTH-1:0] acc);
    case (op_t'(code))
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_ANDN: return a & ~b;
      default: return acc ^ a ^ b;
    endcase
  endfunction

  // Scoreboard: pop/compare on a handshake, then model any accepted beat.
  always @(negedge clk) begin
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] r;
    if (!rst_n) begin
      expQ.delete();
      modelAcc = '0;
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL scoreboard_extra: got %h, required no result", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_parity, out_zero, out_data} !== exp) begin
            miscompares++;
            $display("[TB] FAIL scoreboard: got p=%b z=%b d=%h, required p=%b z=%b d=%h",
                     out_parity, out_zero, out_data, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        r = refOp(in_op, in_a, in_b, modelAcc);
        if (op_t'(in_op) == OP_ACCX) begin
          if (in_last) begin
            expQ.push_back({^r, (r == '0), r});
            modelAcc = '0;
          end else begin
            modelAcc = r;
          end
        end else begin
          expQ.push_back({^r, (r == '0), r});
        end
      end
    end
  end

  task automatic advance();
    @(posedge clk);
    #1;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one beat and return just after the edge that accepts it.
  task automatic send(op_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic last);
    int waited = 0;
    in_op = op; in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        advance();
        break;
      end
      advance();
      waited++;
      if (waited > 200) begin
        vectors++; miscompares++;
        $display("[TB] FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin advance(); n++; end
    vectors++;
    if (out_valid !== 1'b0 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: out_valid=%b pending=%0d, required 0 and 0", out_valid, expQ.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_op = OP_XOR; in_a = 32'hDEAD_BEEF;
    in_b = 32'h1234_5678; in_last = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready);
      end
    end
    vectors++;
    if ({out_valid, out_data, out_parity, out_zero, acc_busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h p=%b z=%b busy=%b, required all 0",
               out_valid, out_data, out_parity, out_zero, acc_busy);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got ready=%b valid=%b, required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ops();
    logic [WIDTH-1:0] expTab [7];
    logic [WIDTH-1:0] e;
    expTab = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h00FF_1234,
               32'hFF0F_EDCB, 32'h000F_0000, 32'hF000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(op_t'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
      e = expTab[i];
      vectors++;
      if ({out_valid, out_parity, out_zero, out_data} !== {1'b1, ^e, (e == '0), e}) begin
        miscompares++;
        $display("[TB] FAIL op_%0d: got v=%b p=%b z=%b d=%h, required v=1 p=%b z=%b d=%h",
                 i, out_valid, out_parity, out_zero, out_data, ^e, (e == '0), e);
      end
    end
    drain();
  endtask

  task automatic test_accumulate();
    out_ready = 1'b1;
    send(OP_ACCX, 32'h1, 32'h2, 1'b0);
    vectors++;
    if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL accx_beat1: got busy=%b valid=%b, required 1 and 0", acc_busy, out_valid);
    end
    send(OP_ACCX, 32'h4, 32'h8, 1'b0);
    send(OP_XOR, 32'h5, 32'h5, 1'b0);
    vectors++;
    if ({out_valid, out_zero, out_data, acc_busy} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL accx_interleave: got v=%b z=%b d=%h busy=%b, required 1 1 0 1",
               out_valid, out_zero, out_data, acc_busy);
    end
    send(OP_ACCX, 32'h10, 32'h20, 1'b1);
    vectors++;
    if ({out_valid, out_data, acc_busy} !== {1'b1, 32'h3F, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL accx_result: got v=%b d=%h busy=%b, required 1 0000003f 0",
               out_valid, out_data, acc_busy);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(OP_AND, 32'h3, 32'h1, 1'b0);
    send(OP_OR, 32'h10, 32'h20, 1'b0);
    in_op = OP_XOR; in_a = 32'hFF; in_b = 32'h0F; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_data !== 32'h1) begin
        miscompares++;
        $display("[TB] FAIL bp_full_%0d: got ready=%b head=%h, required 0 00000001", i, in_ready, out_data);
      end
      advance();
    end
    out_ready = 1'b1;
    advance();
    vectors++;
    if (in_ready !== 1'b1 || out_data !== 32'h30) begin
      miscompares++;
      $display("[TB] FAIL bp_pop: got ready=%b head=%h, required 1 00000030", in_ready, out_data);
    end
    advance();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hF0) begin
      miscompares++;
      $display("[TB] FAIL bp_third: got v=%b d=%h, required 1 000000f0", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    out_ready = 1'b1;
    start = cycles;
    for (int i = 0; i < 20; i++) send(OP_XOR, $urandom, $urandom, 1'b0);
    vectors++;
    if (cycles - start != 20) begin
      miscompares++;
      $display("[TB] FAIL throughput: got %0d cycles for 20 beats, required 20", cycles - start);
    end
    drain();
  endtask

  task automatic test_streaming();
    op_t op;
    randReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = op_t'($urandom_range(0, 7));
      send(op, $urandom, (i % 9 == 0) ? 32'h0 : $urandom, ($urandom_range(0, 2) == 0));
    end
    send(OP_ACCX, $urandom, $urandom, 1'b1);
    randReady = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(OP_ACCX, 32'h7, 32'h9, 1'b0);
    send(OP_ACCX, 32'h1, 32'h2, 1'b0);
    send(OP_OR, 32'h1, 32'h2, 1'b0);
    vectors++;
    if (acc_busy !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_before: got busy=%b valid=%b, required 1 and 1", acc_busy, out_valid);
    end
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({out_valid, acc_busy, in_ready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL mid_after: got v=%b busy=%b ready=%b, required 0 0 1", out_valid, acc_busy, in_ready);
    end
    out_ready = 1'b1;
    send(OP_ACCX, 32'h3, 32'h5, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h6) begin
      miscompares++;
      $display("[TB] FAIL mid_accx: got v=%b d=%h, required 1 00000006", out_valid, out_data);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_streaming();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
